load_store_unit: RTL and testbench

- Multi-cycle, parametrised load/store unit for the CSE-BUBBLE datapath.
- Computes the effective address as base plus sign-extended 16-bit offset, checks alignment, and accesses an internal byte-lane data memory after a configurable latency.
- Supports word and byte accesses; signed byte loads are sign-extended.
- Sits after instruction decode; the decoder supplies the operation and the rs/rt-derived operands.

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_data_mem.sv | 34 +++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: operation codes, FSM states, lane count.
package lsu_pkg;

  typedef enum logic [1:0] {
    OP_LW = 2'b00,
    OP_SW = 2'b01,
    OP_LB = 2'b10,
    OP_SB = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } lsu_state_e;

  localparam int BYTE_LANES = 4;

endpackage

// File: rtl/lsu_data_mem.sv
// Single-port data RAM with per-lane byte-enable write and registered word read.
module lsu_data_mem
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTE_LANES; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: EA generation, alignment check, latency-timed memory commit.
// Optional upper-address bounds check enabled by defining LSU_BOUNDS_CHECK_EN.
//
// state    | meaning
// S_IDLE   | ready; accept request, compute EA, screen for errors
// S_ACCESS | latency countdown; commit memory op when counter hits zero
// S_RESP   | one-cycle response pulse, then back to idle
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] base,
  input  logic [15:0]       offset,
  input  logic [DATA_W-1:0] store_data,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [DATA_W-1:0] resp_addr,
  output logic [DATA_W-1:0] load_data
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  lsu_op_e           op_q, op_d;
  logic [DATA_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] sd_q, sd_d;
  logic              resp_err_q, resp_err_d;
  logic [DATA_W-1:0] resp_addr_q, resp_addr_d;
  logic [DATA_W-1:0] load_data_q, load_data_d;

  logic [DATA_W-1:0]     ea_calc;
  logic                  misalign;
  logic                  oob;
  logic [ADDR_W-1:0]     mem_addr;
  logic                  mem_we;
  logic [BYTE_LANES-1:0] mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;
  logic [7:0]            rd_byte;

  always_comb begin
    ea_calc  = base + {{(DATA_W-16){offset[15]}}, offset};
    misalign = (op[1] == 1'b0) && (ea_calc[1:0] != 2'b00);
`ifdef LSU_BOUNDS_CHECK_EN
    oob      = (ea_calc >> (ADDR_W + 2)) != '0;
`else
    oob      = 1'b0;
`endif
    // Present the incoming EA while idle so the registered read is ready one cycle after accept.
    mem_addr = (state_q == S_IDLE) ? ea_calc[ADDR_W+1:2] : ea_q[ADDR_W+1:2];
    rd_byte  = mem_rdata[{ea_q[1:0], 3'b000} +: 8];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    ea_d        = ea_q;
    sd_d        = sd_q;
    resp_err_d  = resp_err_q;
    resp_addr_d = resp_addr_q;
    load_data_d = load_data_q;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_wdata   = sd_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d = lsu_op_e'(op);
          ea_d = ea_calc;
          sd_d = store_data;
          if (misalign || oob) begin
            resp_err_d  = 1'b1;
            resp_addr_d = ea_calc;
            load_data_d = '0;
            state_d     = S_RESP;
          end else begin
            cnt_d   = CNT_W'(MEM_LATENCY - 1);
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          resp_err_d  = 1'b0;
          resp_addr_d = ea_q;
          load_data_d = '0;
          case (op_q)
            OP_LW: load_data_d = mem_rdata;
            OP_LB: load_data_d = {{(DATA_W-8){rd_byte[7]}}, rd_byte};
            OP_SW: begin
              mem_we = 1'b1;
              mem_be = '1;
            end
            OP_SB: begin
              mem_we    = 1'b1;
              mem_be    = BYTE_LANES'(1) << ea_q[1:0];
              mem_wdata = {BYTE_LANES{sd_q[7:0]}};
            end
            default: load_data_d = '0;
          endcase
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_LW;
      ea_q        <= '0;
      sd_q        <= '0;
      resp_err_q  <= 1'b0;
      resp_addr_q <= '0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      ea_q        <= ea_d;
      sd_q        <= sd_d;
      resp_err_q  <= resp_err_d;
      resp_addr_q <= resp_addr_d;
      load_data_q <= load_data_d;
    end
  end

  lsu_data_mem #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .be   (mem_be),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  assign req_ready  = (state_q == S_IDLE) && !reset;
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = resp_err_q;
  assign resp_addr  = resp_addr_q;
  assign load_data  = load_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 10;
  localparam int MEM_LATENCY = 2;

  localparam logic [1:0] LW = 2'b00, SW = 2'b01, LB = 2'b10, SB = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        op;
  logic [DATA_W-1:0] base;
  logic [15:0]       offset;
  logic [DATA_W-1:0] store_data;
  logic              resp_valid;
  logic              resp_err;
  logic [DATA_W-1:0] resp_addr;
  logic [DATA_W-1:0] load_data;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .op        (op),
    .base      (base),
    .offset    (offset),
    .store_data(store_data),
    .resp_valid(resp_valid),
    .resp_err  (resp_err),
    .resp_addr (resp_addr),
    .load_data (load_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    logic [31:0] sd;
    logic        err;
    logic [31:0] addr;
    logic [31:0] data;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Issue one request at a negedge-safe point and check latency, response fields and pulse width.
  task automatic do_req(input string tag, input logic [1:0] o, input logic [31:0] b,
                        input logic [15:0] off, input logic [31:0] sd,
                        input logic e_err, input logic [31:0] e_addr, input logic [31:0] e_data);
    int n;
    int exp_lat;
    chk({tag, " ready_before"}, {31'd0, req_ready}, 32'd1);
    op = o; base = b; offset = off; store_data = sd; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    exp_lat = e_err ? 0 : MEM_LATENCY;
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " err"}, {31'd0, resp_err}, {31'd0, e_err});
    chk({tag, " addr"}, resp_addr, e_addr);
    chk({tag, " data"}, load_data, e_data);
    @(posedge clk);
    #1;
    chk({tag, " pulse_end"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, " addr_hold"}, resp_addr, e_addr);
  endtask

  initial begin
    vecs[0]  = '{SW, 32'd8,  16'd12,     32'hDEADBEEF, 1'b0, 32'd20, 32'h0};
    vecs[1]  = '{LW, 32'd8,  16'd12,     32'h0,        1'b0, 32'd20, 32'hDEADBEEF};
    vecs[2]  = '{SB, 32'd20, 16'd1,      32'h00000080, 1'b0, 32'd21, 32'h0};
    vecs[3]  = '{LB, 32'd20, 16'd1,      32'h0,        1'b0, 32'd21, 32'hFFFFFF80};
    vecs[4]  = '{LW, 32'd20, 16'd0,      32'h0,        1'b0, 32'd20, 32'hDEAD80EF};
    vecs[5]  = '{LW, 32'd10, 16'd12,     32'h0,        1'b1, 32'd22, 32'h0};
    vecs[6]  = '{LW, 32'd20, 16'd0,      32'h0,        1'b0, 32'd20, 32'hDEAD80EF};
    vecs[7]  = '{LW, 32'd24, 16'hFFFC,   32'h0,        1'b0, 32'd20, 32'hDEAD80EF};
    vecs[8]  = '{SW, 32'd20, 16'd2,      32'h55555555, 1'b1, 32'd22, 32'h0};
    vecs[9]  = '{LW, 32'd20, 16'd0,      32'h0,        1'b0, 32'd20, 32'hDEAD80EF};
    vecs[10] = '{LB, 32'd20, 16'd3,      32'h0,        1'b0, 32'd23, 32'hFFFFFFDE};
    vecs[11] = '{LB, 32'd20, 16'd0,      32'h0,        1'b0, 32'd20, 32'hFFFFFFEF};
    vecs[12] = '{LB, 32'd24, 16'hFFFE,   32'h0,        1'b0, 32'd22, 32'hFFFFFFAD};
    vecs[13] = '{SW, 32'd24, 16'd0,      32'h11223344, 1'b0, 32'd24, 32'h0};
    vecs[14] = '{SB, 32'd24, 16'd2,      32'h0000AB5A, 1'b0, 32'd26, 32'h0};
    vecs[15] = '{LB, 32'd24, 16'd2,      32'h0,        1'b0, 32'd26, 32'h0000005A};
    vecs[16] = '{LW, 32'd24, 16'd0,      32'h0,        1'b0, 32'd24, 32'h115A3344};
    vecs[17] = '{LB, 32'd24, 16'd1,      32'h0,        1'b1 ^ 1'b1, 32'd25, 32'h00000033};

    reset = 1'b1; req_valid = 1'b0; op = LW; base = '0; offset = '0; store_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {31'd0, req_ready}, 32'd0);
    chk("reset valid", {31'd0, resp_valid}, 32'd0);
    chk("reset err", {31'd0, resp_err}, 32'd0);
    chk("reset addr", resp_addr, 32'd0);
    chk("reset data", load_data, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready after release", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].op, vecs[i].base, vecs[i].off, vecs[i].sd,
             vecs[i].err, vecs[i].addr, vecs[i].data);
    end

    // Wrap-around EA and upper-bit handling around word index 0.
    do_req("sw_idx0", SW, 32'd0, 16'd0, 32'hCAFEF00D, 1'b0, 32'd0, 32'h0);
    do_req("wrap_ea", LW, 32'hFFFFFFFC, 16'd4, 32'h0, 1'b0, 32'd0, 32'hCAFEF00D);
`ifdef LSU_BOUNDS_CHECK_EN
    do_req("bounds", LW, 32'd4096, 16'd0, 32'h0, 1'b1, 32'd4096, 32'h0);
`else
    do_req("bounds", LW, 32'd4096, 16'd0, 32'h0, 1'b0, 32'd4096, 32'hCAFEF00D);
`endif

    // Requests held while busy are ignored: only one response for one accept.
    op = LW; base = 32'd24; offset = 16'd0; store_data = '0; req_valid = 1'b1;
    @(posedge clk);
    #1;
    op = SW; store_data = 32'hFFFFFFFF;
    chk("busy ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("busy resp", {31'd0, resp_valid}, 32'd1);
    chk("busy data", load_data, 32'h115A3344);
    @(posedge clk);
    #1;
    do_req("busy after", LW, 32'd24, 16'd0, 32'h0, 1'b0, 32'd24, 32'h115A3344);

    // Reset mid-store: earlier committed store persists, interrupted one is dropped.
    do_req("rst pre sw", SW, 32'd40, 16'd0, 32'hA5A5A5A5, 1'b0, 32'd40, 32'h0);
    op = SW; base = 32'd40; offset = 16'd0; store_data = 32'h12345678; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst ready", {31'd0, req_ready}, 32'd0);
    chk("midrst valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst addr", resp_addr, 32'd0);
    chk("midrst data", load_data, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst ready after", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    do_req("midrst lw", LW, 32'd40, 16'd0, 32'h0, 1'b0, 32'd40, 32'hA5A5A5A5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
